// File: rtl/td4_prog_loader.sv
// UART program loader for the TD4 core: fills a 16x8 program memory,
// verifies the checksum, then releases the core and serves its fetches.
module td4_prog_loader #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rxd,
    input  logic [3:0] ip,
    output logic [7:0] instr,
    output logic       cpu_reset_n,
    output logic       loading,
    output logic       err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        SYNC, LOAD, CHECK, RUN
    } ld_state_t;

    logic            rxd_s1_q, rxd_s2_q, rxd_prev_q;
    rx_state_t       rx_state_q, rx_state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            rx_valid_q, rx_valid_d;
    logic            rx_ferr_q, rx_ferr_d;

    ld_state_t       state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic            err_q, err_d;
    logic            cpu_reset_n_q, cpu_reset_n_d;
    logic            loading_q, loading_d;
    logic            mem_we;
    logic [7:0]      mem_q [16];

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shreg_d    = shreg_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_s2_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = CW'(1);
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d  = CW'(1);
                    bit_idx_d  = 3'd0;
                    rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL) begin
                    clk_cnt_d = CW'(1);
                    shreg_d   = {rxd_s2_q, shreg_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == FULL) begin
                    rx_state_d = RX_IDLE;
                    rx_valid_d = rxd_s2_q;
                    rx_ferr_d  = !rxd_s2_q;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            SYNC, RUN: begin
                if (rx_valid_q && shreg_q == 8'hA5) begin
                    state_d = LOAD;
                    cnt_d   = 4'd0;
                    sum_d   = 8'd0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (rx_ferr_q) begin
                    state_d = SYNC;
                    err_d   = 1'b1;
                end else if (rx_valid_q) begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + shreg_q;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) state_d = CHECK;
                end
            end
            CHECK: begin
                if (rx_ferr_q) begin
                    state_d = SYNC;
                    err_d   = 1'b1;
                end else if (rx_valid_q) begin
                    if (shreg_q == sum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = SYNC;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        cpu_reset_n_d = (state_d == RUN);
        loading_d = (state_d == LOAD) || (state_d == CHECK);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rxd_s1_q      <= 1'b1;
            rxd_s2_q      <= 1'b1;
            rxd_prev_q    <= 1'b1;
            rx_state_q    <= RX_IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= 3'd0;
            shreg_q       <= 8'd0;
            rx_valid_q    <= 1'b0;
            rx_ferr_q     <= 1'b0;
            state_q       <= SYNC;
            cnt_q         <= 4'd0;
            sum_q         <= 8'd0;
            err_q         <= 1'b0;
            cpu_reset_n_q <= 1'b0;
            loading_q     <= 1'b0;
            for (int i = 0; i < 16; i++) mem_q[i] <= 8'd0;
        end else begin
            rxd_s1_q      <= rxd;
            rxd_s2_q      <= rxd_s1_q;
            rxd_prev_q    <= rxd_s2_q;
            rx_state_q    <= rx_state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shreg_q       <= shreg_d;
            rx_valid_q    <= rx_valid_d;
            rx_ferr_q     <= rx_ferr_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sum_q         <= sum_d;
            err_q         <= err_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            loading_q     <= loading_d;
            if (mem_we) mem_q[cnt_q] <= shreg_q;
        end
    end

    assign instr       = mem_q[ip];
    assign cpu_reset_n = cpu_reset_n_q;
    assign loading     = loading_q;
    assign err         = err_q;

endmodule
